// File: rtl/gru_gate_linear_seq.sv
// gru_gate_linear_seq
// Row-sequential vector x matrix linear unit for the GRU datapath.
// One accepted job streams OUT_LEN rows of a selected gate block out of an
// external synchronous weight/bias memory and produces
//     dout[k] = sum_i din[i] * W[base+k][i] + b[base+k]
// in signed fixed point (FRAC fractional bits), rounded half-up and saturated.
// Pipeline: M (memory read) -> P (products) -> S (adder tree) -> O (bias,
// round, saturate). One row per cycle, no stalls.
// Build option: define GRU_LINEAR_BIAS_EN to include the bias term; when it is
// undefined the bias is treated as zero, b_data is ignored and the bias path
// is not built (latency is unchanged).
module gru_gate_linear_seq #(
    parameter int IN_LEN  = 32,
    parameter int OUT_LEN = 32,
    parameter int N_GATES = 3,
    parameter int DATA_W  = 32,
    parameter int FRAC    = 16,
    localparam int AW = (N_GATES * OUT_LEN > 1) ? $clog2(N_GATES * OUT_LEN) : 1,
    localparam int GW = (N_GATES > 1) ? $clog2(N_GATES) : 1,
    localparam int IW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [GW-1:0]              gate_sel,
    input  logic [IN_LEN*DATA_W-1:0]   din,
    output logic                       ready,
    output logic                       w_en,
    output logic [AW-1:0]              w_addr,
    input  logic [IN_LEN*DATA_W-1:0]   w_row,
    input  logic [DATA_W-1:0]          b_data,
    output logic                       dout_valid,
    output logic [DATA_W-1:0]          dout,
    output logic [IW-1:0]              dout_idx,
    output logic                       done
);

    // Product, tree-sum and O-stage accumulator widths.
    localparam int PW  = 2 * DATA_W;
    localparam int SW  = 2 * DATA_W + $clog2(IN_LEN);
    localparam int NP  = 1 << $clog2(IN_LEN);
    localparam int ACW = ((SW > DATA_W + FRAC) ? SW : DATA_W + FRAC) + 2;

    localparam logic [IW-1:0] LAST_IDX = IW'(OUT_LEN - 1);

    localparam logic signed [ACW-1:0] RND_HALF = ACW'(1) <<< (FRAC - 1);
    localparam logic signed [ACW-1:0] SAT_MAX  = {{(ACW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACW-1:0] SAT_MIN  = {{(ACW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    state_t                     state_q, state_d;
    logic [IW-1:0]              cnt_q, cnt_d;
    logic [AW-1:0]              base_q, base_d;
    logic [IN_LEN*DATA_W-1:0]   din_q;
    logic                       accept;
    logic                       issue_c;

    // Pipeline bookkeeping: per-row valid and index travel with the data.
    logic                       m_valid_q, p_valid_q, s_valid_q, o_valid_q;
    logic [IW-1:0]              m_idx_q, p_idx_q, s_idx_q, o_idx_q;
    logic                       done_q;
    logic [DATA_W-1:0]          dout_q;

    // Out-of-range gate selections are never accepted.
    assign accept = start && (state_q == IDLE)
                 && ({{(32-GW){1'b0}}, gate_sel} < 32'(N_GATES));

    // FSM state and job registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Input vector is captured only when a job is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            din_q <= din;
        end
    end

    // Next-state logic: issue one row address per cycle, then wait for the
    // last result to leave the pipeline.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        issue_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    base_d  = AW'({{(32-GW){1'b0}}, gate_sel} * 32'(OUT_LEN));
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                issue_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign w_en   = issue_c;
    assign w_addr = base_q + AW'(cnt_q);

    // ------------------------------------------------------------------
    // Valid / index pipeline (M -> P -> S -> O)
    // ------------------------------------------------------------------
    // Row tags advance one stage per cycle alongside the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            p_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            m_idx_q   <= '0;
            p_idx_q   <= '0;
            s_idx_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            m_valid_q <= issue_c;
            p_valid_q <= m_valid_q;
            s_valid_q <= p_valid_q;
            o_valid_q <= s_valid_q;
            m_idx_q   <= cnt_q;
            p_idx_q   <= m_idx_q;
            s_idx_q   <= p_idx_q;
            done_q    <= s_valid_q && (s_idx_q == LAST_IDX);
        end
    end

    // ------------------------------------------------------------------
    // P stage: one signed product per vector element
    // ------------------------------------------------------------------
    logic signed [PW-1:0] prod_q [IN_LEN];
    logic signed [SW-1:0] leaf_c [NP];

    genvar gi;
    generate
        for (gi = 0; gi < IN_LEN; gi++) begin : g_prod
            // Multiply the latched input element by the row weight that just
            // arrived from memory.
            always_ff @(posedge clk) begin
                if (m_valid_q) begin
                    prod_q[gi] <= PW'($signed(din_q[gi*DATA_W +: DATA_W]))
                                * PW'($signed(w_row[gi*DATA_W +: DATA_W]));
                end
            end
        end

        // Tree leaves, zero-padded up to a power of two.
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            if (gi < IN_LEN) begin : g_real
                assign leaf_c[gi] = SW'(prod_q[gi]);
            end else begin : g_pad
                assign leaf_c[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // S stage: balanced adder tree, wide enough that it cannot overflow
    // ------------------------------------------------------------------
    logic signed [SW-1:0] tree_c;
    logic signed [SW-1:0] sum_q;

    // Pairwise reduction: at stride s, node i absorbs node i+s.
    always_comb begin
        logic signed [SW-1:0] node [NP];
        for (int i = 0; i < NP; i++) begin
            node[i] = leaf_c[i];
        end
        for (int s = 1; s < NP; s = s * 2) begin
            for (int i = 0; i < NP; i = i + 2 * s) begin
                node[i] = node[i] + node[i + s];
            end
        end
        tree_c = node[0];
    end

    // Register the row sum.
    always_ff @(posedge clk) begin
        if (p_valid_q) begin
            sum_q <= tree_c;
        end
    end

`ifdef GRU_LINEAR_BIAS_EN
    // Bias word arrives with the weight row; delay it to line up with the sum.
    logic signed [DATA_W-1:0] bias_p_q, bias_s_q;

    // Carry the bias alongside the P and S stages.
    always_ff @(posedge clk) begin
        bias_p_q <= $signed(b_data);
        bias_s_q <= bias_p_q;
    end
`else
    // Bias path absent: the port stays for drop-in compatibility only.
    logic unused_bias;
    assign unused_bias = ^b_data;
`endif

    // ------------------------------------------------------------------
    // O stage: bias add, round half-up, arithmetic shift, saturate
    // ------------------------------------------------------------------
    logic signed [ACW-1:0] acc_c;
    logic signed [ACW-1:0] rnd_c;
    logic signed [ACW-1:0] shf_c;
    logic [DATA_W-1:0]     sat_c;

    // Rescale the Q(2*FRAC) sum back to Q(FRAC) and clamp to the word range.
    always_comb begin
        acc_c = ACW'(sum_q);
`ifdef GRU_LINEAR_BIAS_EN
        acc_c = acc_c + (ACW'(bias_s_q) <<< FRAC);
`endif
        rnd_c = acc_c + RND_HALF;
        shf_c = rnd_c >>> FRAC;
        if (shf_c > SAT_MAX) begin
            sat_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shf_c < SAT_MIN) begin
            sat_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_c = shf_c[DATA_W-1:0];
        end
    end

    // Result registers hold their value between valid rows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q  <= '0;
            o_idx_q <= '0;
        end else if (s_valid_q) begin
            dout_q  <= sat_c;
            o_idx_q <= s_idx_q;
        end
    end

    assign dout_valid = o_valid_q;
    assign dout       = dout_q;
    assign dout_idx   = o_idx_q;
    assign done       = done_q;

endmodule
